// File: rtl/vga_fetch_engine.sv
// vga_fetch_engine: walks a linear frame buffer over a one-outstanding SRAM req/ack link into a show-ahead pixel FIFO
// Optional build macro VGA_FETCH_UNDERFLOW_CNT_EN adds a 16-bit saturating underflow counter on underflow_cnt.
module vga_fetch_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] FB_BASE = 'h3E80,
  parameter int unsigned WORDS_PER_FRAME = 9600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              frame_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byte_sel,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pix_rd,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              frame_done,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);
  localparam int unsigned CW = $clog2(WORDS_PER_FRAME + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, STALL, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] wcnt;
  logic drop;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic ack, push, pop, uf, last, full_n, uflag;
  assign ack = mem_req & mem_ack;
  assign push = ack & ~drop & ~frame_start;
  assign pop = pix_rd & pix_valid;
  assign uf = pix_rd & ~pix_valid;
  assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign last = wcnt == CW'(WORDS_PER_FRAME - 1);
  assign full_n = cnt_n == (AW+1)'(FIFO_DEPTH);
  assign mem_addr = addr;
  assign mem_byte_sel = 4'b1111;
  assign pix_valid = cnt != '0;
  assign pix_data = pix_valid ? fifo_mem[rp] : '0;
  assign underflow = uflag;
  // State register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= state_n;
  // Next state: restart wins; an accepted word may end the frame or fill the FIFO
  always_comb begin
    state_n = state;
    if (frame_start) state_n = FETCH;
    else if (state == FETCH && push) state_n = last ? DONE : full_n ? STALL : FETCH;
    else if (state == STALL && cnt != (AW+1)'(FIFO_DEPTH)) state_n = FETCH;
  end
  // Handshake and status outputs decoded from state
  always_comb begin
    mem_req = state == FETCH;
    frame_done = state == DONE;
  end
  // Address, word count, FIFO pointers and sticky underflow; a restart during a pending request keeps its address until the ack, which is then dropped
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      addr <= FB_BASE;
      wcnt <= '0;
      drop <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      uflag <= 1'b0;
    end else if (frame_start) begin
      drop <= mem_req & ~mem_ack;
      addr <= (mem_req & ~mem_ack) ? addr : FB_BASE;
      wcnt <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      uflag <= 1'b0;
    end else begin
      if (ack) addr <= drop ? FB_BASE : addr + ADDR_W'(1);
      if (ack) drop <= 1'b0;
      if (push) wp <= wp + AW'(1);
      if (push) wcnt <= wcnt + CW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt_n;
      if (uf) uflag <= 1'b1;
    end
  // FIFO storage write
  always_ff @(posedge clk)
    if (push) fifo_mem[wp] <= mem_rdata;
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] ucnt;
  // Saturating count of reads attempted on an empty FIFO
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) ucnt <= '0;
    else if (frame_start) ucnt <= '0;
    else if (uf && ucnt != 16'hFFFF) ucnt <= ucnt + 16'd1;
  assign underflow_cnt = ucnt;
`else
  assign underflow_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_fetch_engine.sv
// tb_vga_fetch_engine: directed checks of fetch, stall, drain, wait states, restart-while-pending and underflow
module tb_vga_fetch_engine;
  localparam logic [31:0] BASE = 32'h3E80;
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
  localparam logic [15:0] UF_EXP = 16'd3;
`else
  localparam logic [15:0] UF_EXP = 16'd0;
`endif
  logic clk = 0, nrst = 0, frame_start = 0, pix_rd = 0;
  logic mem_req, mem_ack, pix_valid, frame_done, underflow;
  logic [31:0] mem_addr, mem_rdata, pix_data;
  logic [3:0] mem_byte_sel;
  logic [15:0] underflow_cnt;
  logic ack_en = 1;
  int ack_delay = 0, wait_cnt = 0;
  logic [31:0] log_a [64];
  int nlog = 0, unstable = 0;
  logic pend = 0;
  logic [31:0] pend_addr = 0;
  int n_cmp = 0, n_bad = 0;

  vga_fetch_engine #(.DATA_W(32), .ADDR_W(32), .FB_BASE(32'h3E80), .WORDS_PER_FRAME(20), .FIFO_DEPTH(8)) dut (
    .clk(clk), .nrst(nrst), .frame_start(frame_start), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_byte_sel(mem_byte_sel), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pix_rd(pix_rd),
    .pix_valid(pix_valid), .pix_data(pix_data), .frame_done(frame_done), .underflow(underflow),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  assign mem_ack = mem_req & ack_en & (wait_cnt >= ack_delay);
  assign mem_rdata = mem_addr;

  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  always @(posedge clk) begin
    if (pend && (!mem_req || mem_addr != pend_addr)) unstable++;
    if (mem_req && mem_ack && nlog < 64) begin
      log_a[nlog] = mem_addr;
      nlog++;
    end
    pend = mem_req & ~mem_ack;
    pend_addr = mem_addr;
  end

  task automatic pulse_start();
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %0h expected 0", mem_req); end
    n_cmp++; if (mem_addr !== BASE) begin n_bad++; $display("FAIL reset_mem_addr: got %0h expected %0h", mem_addr, BASE); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pix_valid: got %0h expected 0", pix_valid); end
    n_cmp++; if (pix_data !== 32'h0) begin n_bad++; $display("FAIL reset_pix_data: got %0h expected 0", pix_data); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %0h expected 0", frame_done); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow: got %0h expected 0", underflow); end
    n_cmp++; if (underflow_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_underflow_cnt: got %0h expected 0", underflow_cnt); end
    n_cmp++; if (mem_byte_sel !== 4'hF) begin n_bad++; $display("FAIL byte_sel: got %0h expected f", mem_byte_sel); end
    nrst = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL idle_mem_req: got %0h expected 0", mem_req); end
  endtask

  task automatic test_stall_fill();
    nlog = 0; ack_en = 1; ack_delay = 0; pix_rd = 0;
    pulse_start();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL fill_req_rise: got %0h expected 1", mem_req); end
    n_cmp++; if (mem_addr !== BASE) begin n_bad++; $display("FAIL fill_first_addr: got %0h expected %0h", mem_addr, BASE); end
    @(negedge clk);
    n_cmp++; if (pix_valid !== 1'b1) begin n_bad++; $display("FAIL fill_valid_lat: got %0h expected 1", pix_valid); end
    n_cmp++; if (pix_data !== BASE) begin n_bad++; $display("FAIL fill_data_lat: got %0h expected %0h", pix_data, BASE); end
    n_cmp++; if (mem_addr !== BASE + 32'd1) begin n_bad++; $display("FAIL fill_next_addr: got %0h expected %0h", mem_addr, BASE + 32'd1); end
    repeat (10) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req: got %0h expected 0", mem_req); end
    n_cmp++; if (nlog !== 8) begin n_bad++; $display("FAIL stall_nacks: got %0d expected 8", nlog); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (log_a[i] !== BASE + 32'(i)) begin n_bad++; $display("FAIL fill_addr_%0d: got %0h expected %0h", i, log_a[i], BASE + 32'(i)); end
    end
    n_cmp++; if (pix_data !== BASE) begin n_bad++; $display("FAIL stall_head: got %0h expected %0h", pix_data, BASE); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL stall_done: got %0h expected 0", frame_done); end
  endtask

  task automatic test_drain();
    int k = 0;
    bit seen = 0;
    pix_rd = 1;
    for (int c = 0; c < 200 && k < 20; c++) begin
      if (pix_valid) begin
        n_cmp++; if (pix_data !== BASE + 32'(k)) begin n_bad++; $display("FAIL drain_pop_%0d: got %0h expected %0h", k, pix_data, BASE + 32'(k)); end
        k++;
      end
      if (nlog == 20 && !seen) begin
        seen = 1;
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL done_rise: got %0h expected 1", frame_done); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL done_req: got %0h expected 0", mem_req); end
      end
      @(negedge clk);
    end
    pix_rd = 0;
    n_cmp++; if (k !== 20) begin n_bad++; $display("FAIL drain_timeout: got %0d pops expected 20", k); end
    repeat (3) @(negedge clk);
    n_cmp++; if (nlog !== 20) begin n_bad++; $display("FAIL drain_nacks: got %0d expected 20", nlog); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL done_req_hold: got %0h expected 0", mem_req); end
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL done_hold: got %0h expected 1", frame_done); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %0h expected 0", pix_valid); end
  endtask

  task automatic test_ack_delay();
    nlog = 0; unstable = 0; ack_delay = 3; pix_rd = 0;
    pulse_start();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL restart_done_clr: got %0h expected 0", frame_done); end
    n_cmp++; if (mem_addr !== BASE) begin n_bad++; $display("FAIL wait_addr_c1: got %0h expected %0h", mem_addr, BASE); end
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_addr !== BASE || mem_req !== 1'b1) begin n_bad++; $display("FAIL wait_hold_c3: got req %0h addr %0h expected 1 %0h", mem_req, mem_addr, BASE); end
    n_cmp++; if (mem_ack !== 1'b0) begin n_bad++; $display("FAIL wait_noack_c3: got %0h expected 0", mem_ack); end
    @(negedge clk);
    n_cmp++; if (mem_ack !== 1'b1) begin n_bad++; $display("FAIL wait_ack_c4: got %0h expected 1", mem_ack); end
    @(negedge clk);
    n_cmp++; if (mem_addr !== BASE + 32'd1) begin n_bad++; $display("FAIL wait_addr_c5: got %0h expected %0h", mem_addr, BASE + 32'd1); end
    n_cmp++; if (pix_data !== BASE) begin n_bad++; $display("FAIL wait_head: got %0h expected %0h", pix_data, BASE); end
    for (int c = 0; c < 100 && nlog < 6; c++) @(negedge clk);
    n_cmp++; if (nlog < 6) begin n_bad++; $display("FAIL wait_timeout: got %0d acks expected 6", nlog); end
    for (int i = 0; i < nlog; i++) begin
      n_cmp++; if (log_a[i] !== BASE + 32'(i)) begin n_bad++; $display("FAIL wait_seq_%0d: got %0h expected %0h", i, log_a[i], BASE + 32'(i)); end
    end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL wait_stable: got %0d changes expected 0", unstable); end
  endtask

  task automatic test_restart_pending();
    bit found = 0;
    ack_delay = 0; ack_en = 1;
    @(negedge clk);
    pulse_start();
    for (int c = 0; c < 30; c++) begin
      if (mem_req === 1'b1 && mem_addr === BASE + 32'd5) begin found = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL pend_find: got %0h expected %0h", mem_addr, BASE + 32'd5); end
    n_cmp++; if (pix_valid !== 1'b1) begin n_bad++; $display("FAIL pend_prefill: got %0h expected 1", pix_valid); end
    ack_en = 0; frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== BASE + 32'd5) begin n_bad++; $display("FAIL pend_hold: got req %0h addr %0h expected 1 %0h", mem_req, mem_addr, BASE + 32'd5); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL pend_flush: got %0h expected 0", pix_valid); end
    @(negedge clk);
    ack_en = 1;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== BASE) begin n_bad++; $display("FAIL pend_restart: got req %0h addr %0h expected 1 %0h", mem_req, mem_addr, BASE); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL pend_dropped: got %0h expected 0", pix_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL pend_done: got %0h expected 0", frame_done); end
    @(negedge clk);
    n_cmp++; if (pix_data !== BASE) begin n_bad++; $display("FAIL pend_first_word: got %0h expected %0h", pix_data, BASE); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL pend_stable: got %0d changes expected 0", unstable); end
  endtask

  task automatic test_underflow();
    ack_en = 0; pix_rd = 0;
    pulse_start();
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL uf_clr_start: got %0h expected 0", underflow); end
    n_cmp++; if (underflow_cnt !== 16'd0) begin n_bad++; $display("FAIL uf_cnt_clr_start: got %0h expected 0", underflow_cnt); end
    pix_rd = 1;
    @(negedge clk);
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL uf_rise: got %0h expected 1", underflow); end
    repeat (2) @(negedge clk);
    pix_rd = 0;
    n_cmp++; if (underflow_cnt !== UF_EXP) begin n_bad++; $display("FAIL uf_cnt: got %0d expected %0d", underflow_cnt, UF_EXP); end
    @(negedge clk);
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky: got %0h expected 1", underflow); end
    n_cmp++; if (underflow_cnt !== UF_EXP) begin n_bad++; $display("FAIL uf_cnt_hold: got %0d expected %0d", underflow_cnt, UF_EXP); end
    pulse_start();
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL uf_clear: got %0h expected 0", underflow); end
    n_cmp++; if (underflow_cnt !== 16'd0) begin n_bad++; $display("FAIL uf_cnt_clear: got %0d expected 0", underflow_cnt); end
  endtask

  initial begin
    test_reset();
    test_stall_fill();
    test_drain();
    test_ack_delay();
    test_restart_pending();
    test_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_fetch_engine.md
# vga_fetch_engine

Parametrised frame-buffer fetch engine between the SRAM arbiter and the VGA pixel serialiser. It walks a linear frame buffer from a configurable base address and issues one-outstanding word reads over a req/ack handshake. Returned words go into a show-ahead FIFO, which the VGA side drains one word at a time. Frame restart, FIFO flow control and underflow detection are built in, so the VGA timing logic never has to track SRAM addresses.

## Interface
- DATA_W, 32, SRAM word / pixel-word width
- ADDR_W, 32, SRAM address width; addresses are word addresses, increment by 1
- FB_BASE, 32'h3E80, first frame-buffer word address
- WORDS_PER_FRAME, 9600, words fetched per frame (640x480 at 1 bpp); must be ≥ 1
- FIFO_DEPTH, 8, prefetch FIFO entries; power of two, ≥ 2

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse: flush and restart fetch at FB_BASE
- mem_req  out  1  read request; held until mem_ack
- mem_addr  out  ADDR_W  request address; stable while mem_req high
- mem_byte_sel  out  4  constant 4'b1111
- mem_ack  in  1  request accepted, mem_rdata valid this cycle
- mem_rdata  in  DATA_W  read data
- pix_rd  in  1  VGA pops FIFO head
- pix_valid  out  1  FIFO non-empty
- pix_data  out  DATA_W  FIFO head word; 0 when empty
- frame_done  out  1  all WORDS_PER_FRAME words fetched; held until next frame_start
- underflow  out  1  sticky: pix_rd while empty; cleared by frame_start
- underflow_cnt  out  16  see Configuration

## Operation
- States: IDLE, FETCH, STALL, DONE.
- Reset values:
  - state IDLE
  - mem_req 0, mem_addr FB_BASE
  - FIFO empty, pix_valid 0, pix_data 0
  - frame_done 0, underflow 0, underflow_cnt 0
  - word counter 0
- IDLE → FETCH on frame_start.
- FETCH:
  - mem_req = 1 with mem_addr = current address.
  - On mem_ack: write mem_rdata to the FIFO, increment address and word counter.
  - If the count reaches WORDS_PER_FRAME → DONE.
  - Else if no FIFO slot remains for the next word (occupancy after this cycle's push/pop equals FIFO_DEPTH) → STALL.
  - Else stay in FETCH with mem_req held high.
- STALL: mem_req = 0. Return to FETCH when occupancy < FIFO_DEPTH.
- DONE: mem_req = 0, frame_done = 1. The FIFO keeps draining.
- frame_start in any state:
  - Flush the FIFO, address ← FB_BASE, counter ← 0.
  - Clear frame_done and underflow.
  - Go to FETCH.
- frame_start while mem_req = 1 without mem_ack:
  - The request stays asserted with its old address until acked (the handshake is never broken).
  - That ack's data is discarded. The restart at FB_BASE begins the next cycle.
  - frame_start coinciding with mem_ack also discards that word.
- Pop: pix_rd & pix_valid removes the head. Simultaneous push and pop keep occupancy constant.
- pix_rd while empty: no state change except underflow ← 1.
- Address arithmetic is unsigned ADDR_W modulo 2^ADDR_W. The word counter is $clog2(WORDS_PER_FRAME+1) bits.

## Timing
- frame_start at cycle 0 → mem_req = 1, mem_addr = FB_BASE at cycle 1.
- mem_ack at cycle n:
  - pix_valid = 1 and pix_data = that word at cycle n+1.
  - If a slot remains, the next address is on mem_addr at n+1 with mem_req still high.
  - Peak rate is 1 word/cycle with a zero-wait arbiter.
- Pop at cycle n → the new head is visible at n+1.
- Leaving STALL: mem_req rises the cycle after occupancy drops below FIFO_DEPTH.
- frame_done rises the cycle after the final ack.
- underflow rises the cycle after the offending pix_rd.
- mem_req never falls without mem_ack except on the FETCH→STALL/DONE transitions, and those occur only on an ack cycle.

## Configuration
- VGA_FETCH_UNDERFLOW_CNT_EN defined: underflow_cnt is a 16-bit saturating count (stops at 16'hFFFF) of pix_rd-while-empty cycles. It is cleared by frame_start and by reset.
- Undefined: underflow_cnt is tied to 0 and no counter logic is built. The sticky underflow flag is present in both builds.

## Test plan
- Reset, frame_start, always-ack arbiter returning rdata = address, FIFO_DEPTH = 8, no pops → mem_addr 0x3E80..0x3E87 accepted, then mem_req = 0 (STALL), pix_data = 0x3E80.
- Same, then pix_rd every cycle, WORDS_PER_FRAME = 20 → pops return 0x3E80..0x3E93 in order, frame_done = 1 after the 20th ack, mem_req stays 0.
- Arbiter with a 3-cycle ack delay → mem_addr stable across the wait, no duplicate or skipped addresses.
- frame_start while a request to 0x3E85 is pending; ack arrives 2 cycles later → that word is dropped, FIFO is empty, next request is 0x3E80, frame_done = 0.
- pix_rd on an empty FIFO for 3 cycles → underflow = 1, underflow_cnt = 3 with VGA_FETCH_UNDERFLOW_CNT_EN and 0 without; frame_start clears both.
